debounce_bank: RTL and testbench

//  Multi-channel debouncer for buttons/switches feeding the processor I/O block.

---
 rtl/debounce_bank_if.sv | 15 +
 rtl/debounce_bank.sv | 115 +++++++++++
 tb/tb_debounce_bank.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/debounce_bank_if.sv
// Bundled pin-side signals of the debounce bank: raw inputs, limit and registered outputs.
interface debounce_bank_if #(
    parameter int CHANNELS = 16,
    parameter int CNT_W    = 32
);
    logic [CHANNELS-1:0] din;
    logic [CNT_W-1:0]    limit;
    logic [CHANNELS-1:0] dout;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;
    logic                changed;

    modport master (output din, limit, input dout, rise, fall, changed);
    modport slave  (input din, limit, output dout, rise, fall, changed);
endinterface

// File: rtl/debounce_bank.sv
// Multi-channel debouncer: per-lane synchroniser and stable-time counter, with
// registered level, rise/fall pulses and a bank-wide changed strobe.
module debounce_lane #(
    parameter int   CNT_W       = 32,
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_BIT     = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             din_i,
    input  logic [CNT_W-1:0] lim_i,
    output logic             dout_o,
    output logic             rise_o,
    output logic             fall_o,
    output logic             commit_o
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   dout_q, dout_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   commit;
    logic                   s;
    logic [CNT_W:0]         cnt_inc;

    assign sync_d  = {sync_q[SYNC_STAGES-2:0], din_i};
    assign s       = sync_q[SYNC_STAGES-1];
    // One extra bit so the compare stays correct when cnt_q is all ones.
    assign cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

    always_comb begin
        cnt_d  = '0;
        dout_d = dout_q;
        commit = 1'b0;
        if (s != dout_q) begin
            if (cnt_inc >= {1'b0, lim_i}) begin
                commit = 1'b1;
                dout_d = s;
            end else begin
                cnt_d = cnt_inc[CNT_W-1:0];
            end
        end
        rise_d = commit & s;
        fall_d = commit & ~s;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= {SYNC_STAGES{RST_BIT}};
            cnt_q  <= '0;
            dout_q <= RST_BIT;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign dout_o   = dout_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign commit_o = commit;
endmodule

module debounce_bank #(
    parameter int                 CHANNELS    = 16,
    parameter int                 FRQ         = 50000000,
    parameter int                 TIME_MS     = 1,
    parameter int                 DEF_LIMIT   = (FRQ / 1000) * TIME_MS,
    parameter int                 CNT_W       = 32,
    parameter int                 SYNC_STAGES = 2,
    parameter logic [CHANNELS-1:0] RESET_VAL  = '0
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    debounce_bank_if.slave bus
);
    logic [CNT_W-1:0]    eff_lim;
    logic [CHANNELS-1:0] dout, rise, fall, commit;
    logic                changed_q, changed_d;

    assign eff_lim   = (bus.limit == '0) ? CNT_W'(DEF_LIMIT) : bus.limit;
    assign changed_d = |commit;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        debounce_lane #(
            .CNT_W      (CNT_W),
            .SYNC_STAGES(SYNC_STAGES),
            .RST_BIT    (RESET_VAL[i])
        ) u_lane (
            .clk_i   (clk_i),
            .rst_n_i (rst_n_i),
            .din_i   (bus.din[i]),
            .lim_i   (eff_lim),
            .dout_o  (dout[i]),
            .rise_o  (rise[i]),
            .fall_o  (fall[i]),
            .commit_o(commit[i])
        );
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) changed_q <= 1'b0;
        else          changed_q <= changed_d;
    end

    assign bus.dout    = dout;
    assign bus.rise    = rise;
    assign bus.fall    = fall;
    assign bus.changed = changed_q;
endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank: 4 channels, default limit 8, 2-stage sync.
module tb_debounce_bank;
    localparam int CH = 4;
    localparam int CW = 32;

    logic clk = 1'b0;
    logic clk_en = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic [CH-1:0] acc;

    debounce_bank_if #(.CHANNELS(CH), .CNT_W(CW)) bus ();

    debounce_bank #(
        .CHANNELS(CH), .FRQ(8000), .TIME_MS(1), .CNT_W(CW),
        .SYNC_STAGES(2), .RESET_VAL(4'b0000)
    ) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (bus.slave)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic outs(input string tag, input logic [3:0] d, input logic [3:0] r,
                        input logic [3:0] f, input logic c);
        chk({tag, ".dout"}, 32'(bus.dout), 32'(d));
        chk({tag, ".rise"}, 32'(bus.rise), 32'(r));
        chk({tag, ".fall"}, 32'(bus.fall), 32'(f));
        chk({tag, ".chg"},  32'(bus.changed), 32'(c));
    endtask

    initial begin
        bus.din   = 4'h0;
        bus.limit = '0;
        // 1: asynchronous reset with no clock running
        #2;
        bus.din = 4'hF;
        rst_n   = 1'b0;
        #1;
        outs("t1_rst_noclk", 4'h0, 4'h0, 4'h0, 1'b0);
        clk_en = 1'b1;
        tick(2);
        outs("t1_rst_held", 4'h0, 4'h0, 4'h0, 1'b0);
        rst_n = 1'b1;
        tick(9);
        outs("t1_edge9", 4'h0, 4'h0, 4'h0, 1'b0);
        tick(1);
        outs("t1_edge10", 4'hF, 4'hF, 4'h0, 1'b1);
        tick(1);
        outs("t1_after", 4'hF, 4'h0, 4'h0, 1'b0);

        // 2: single-channel rise with default limit
        bus.din = 4'h0;
        tick(10);
        outs("t2_clear", 4'h0, 4'h0, 4'hF, 1'b1);
        tick(1);
        bus.din = 4'h2;
        tick(9);
        outs("t2_edge9", 4'h0, 4'h0, 4'h0, 1'b0);
        tick(1);
        outs("t2_edge10", 4'h2, 4'h2, 4'h0, 1'b1);
        tick(1);
        outs("t2_after", 4'h2, 4'h0, 4'h0, 1'b0);

        // 3: 7-cycle glitch dropped, 8-cycle pulse accepted
        bus.din = 4'h6;
        acc = '0;
        for (int i = 0; i < 7; i++) begin
            tick(1);
            acc |= bus.rise | bus.fall;
        end
        bus.din = 4'h2;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            acc |= bus.rise | bus.fall;
        end
        chk("t3_glitch_pulses", 32'(acc), 32'h0);
        chk("t3_glitch_dout", 32'(bus.dout), 32'h2);
        bus.din = 4'h6;
        tick(8);
        bus.din = 4'h2;
        tick(1);
        chk("t3_len8_pre", 32'(bus.dout), 32'h2);
        tick(1);
        outs("t3_len8", 4'h6, 4'h4, 4'h0, 1'b1);
        tick(20);
        chk("t3_back", 32'(bus.dout), 32'h2);

        // 4: simultaneous rise and fall on different channels
        bus.din = 4'hA;
        tick(10);
        outs("t4_setup", 4'hA, 4'h8, 4'h0, 1'b1);
        tick(1);
        bus.din = 4'h3;
        tick(9);
        chk("t4_edge9", 32'(bus.dout), 32'hA);
        tick(1);
        outs("t4_both", 4'h3, 4'h1, 4'h8, 1'b1);
        tick(1);
        outs("t4_after", 4'h3, 4'h0, 4'h0, 1'b0);

        // 5: programmed limit, then limit lowered mid-count
        bus.limit = 32'd3;
        bus.din   = 4'h7;
        tick(4);
        chk("t5_lim3_pre", 32'(bus.dout), 32'h3);
        tick(1);
        outs("t5_lim3", 4'h7, 4'h4, 4'h0, 1'b1);
        bus.limit = '0;
        bus.din   = 4'h3;
        tick(7);
        chk("t5_cnt5", 32'(bus.dout), 32'h7);
        bus.limit = 32'd2;
        tick(1);
        outs("t5_newlim", 4'h3, 4'h0, 4'h4, 1'b1);
        bus.limit = '0;

        // 6: reset mid-count drops DOUT silently, full delay afterwards
        bus.din = 4'h1;
        tick(6);
        chk("t6_pre", 32'(bus.dout), 32'h3);
        rst_n   = 1'b0;
        bus.din = 4'h2;
        #1;
        outs("t6_rst", 4'h0, 4'h0, 4'h0, 1'b0);
        tick(2);
        outs("t6_rst_held", 4'h0, 4'h0, 4'h0, 1'b0);
        rst_n = 1'b1;
        tick(9);
        outs("t6_edge9", 4'h0, 4'h0, 4'h0, 1'b0);
        tick(1);
        outs("t6_edge10", 4'h2, 4'h2, 4'h0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
